// File: rtl/mem_io_responder.sv
// Byte-wide memory responder: 128 KB RAM plus an I/O window at 0x3xxxx
// holding the UART TX FIFO, UART RX pop, cycle counter readout and program-stop flag.
module mem_io_responder #(
    parameter int RAM_ADDR_W    = 17,
    parameter int TXF_DEPTH_LOG = 3,
    parameter int FULL_MARGIN   = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [31:0] mem_a,
    input  logic [7:0]  mem_dout,
    input  logic        mem_wr,
    output logic [7:0]  mem_din,
    output logic        io_buffer_full,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        program_finish,
    output logic        tx_overflow
);

    localparam int TXF_DEPTH = 1 << TXF_DEPTH_LOG;
    localparam int CW        = TXF_DEPTH_LOG + 1;
    localparam logic [CW-1:0]            DEPTH_C    = CW'(TXF_DEPTH);
    localparam logic [CW-1:0]            FULL_LVL_C = CW'(TXF_DEPTH - FULL_MARGIN);
    localparam logic [CW-1:0]            CNT_ONE_C  = CW'(1);
    localparam logic [TXF_DEPTH_LOG-1:0] PTR_ONE_C  = TXF_DEPTH_LOG'(1);

    logic [7:0]               ram_r [2**RAM_ADDR_W];
    logic [7:0]               fifo_r [TXF_DEPTH];
    logic [TXF_DEPTH_LOG-1:0] wr_ptr_r, rd_ptr_r;
    logic [CW-1:0]            count_r, count_nxt_s;
    logic                     tx_valid_r, buf_full_r;

    logic [7:0]  mem_din_r;
    logic        rx_ready_r, finish_r, ovf_r;
    logic [31:0] counter_r, snap_r;

    logic                  io_s, rd_s, wr_s;
    logic [2:0]            io_reg_s;
    logic [RAM_ADDR_W-1:0] ram_idx_s;
    logic [7:0]            rd_data_s, push_data_s;
    logic                  push_s, pop_s, full_s, accept_s, ovf_s, finish_set_s;
    logic                  unused_s;

    assign unused_s = ^mem_a[31:18];

    // Address decode and request qualification
    always_comb begin
        io_s      = (mem_a[17:16] == 2'b11);
        io_reg_s  = mem_a[2:0];
        ram_idx_s = mem_a[RAM_ADDR_W-1:0];
        rd_s      = rdy_in & ~mem_wr;
        wr_s      = rdy_in & mem_wr;
    end

    // Read-data mux; counter byte 0 comes live, bytes 1-3 from the snapshot
    always_comb begin
        rd_data_s = 8'h00;
        if (io_s) begin
            case (io_reg_s)
                3'd0:    rd_data_s = rx_valid ? rx_data : 8'h00;
                3'd4:    rd_data_s = counter_r[7:0];
                3'd5:    rd_data_s = snap_r[15:8];
                3'd6:    rd_data_s = snap_r[23:16];
                3'd7:    rd_data_s = snap_r[31:24];
                default: rd_data_s = 8'h00;
            endcase
        end else begin
            rd_data_s = ram_r[ram_idx_s];
        end
    end

    // TX push/pop decisions; a full FIFO still accepts when it pops the same cycle
    always_comb begin
        push_s       = 1'b0;
        push_data_s  = 8'h00;
        finish_set_s = 1'b0;
        if (wr_s && io_s) begin
            case (io_reg_s)
                3'd0: begin
                    push_s      = (mem_dout != 8'h00);
                    push_data_s = mem_dout;
                end
                3'd4: begin
                    push_s       = 1'b1;
                    push_data_s  = 8'h00;
                    finish_set_s = 1'b1;
                end
                default: push_s = 1'b0;
            endcase
        end else begin
            push_s = 1'b0;
        end
        pop_s    = (count_r != {CW{1'b0}}) & tx_ready;
        full_s   = (count_r == DEPTH_C);
        accept_s = push_s & (~full_s | pop_s);
        ovf_s    = push_s & full_s & ~pop_s;
        case ({accept_s, pop_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE_C;
            2'b01:   count_nxt_s = count_r - CNT_ONE_C;
            default: count_nxt_s = count_r;
        endcase
    end

    // RAM write port; contents are deliberately left unreset
    always_ff @(posedge clk_in) begin
        if (wr_s && !io_s) begin
            ram_r[ram_idx_s] <= mem_dout;
        end
    end

    // Read response, RX pop pulse, cycle counter, snapshot and sticky flags
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            mem_din_r  <= 8'h00;
            rx_ready_r <= 1'b0;
            counter_r  <= 32'h0000_0000;
            snap_r     <= 32'h0000_0000;
            finish_r   <= 1'b0;
            ovf_r      <= 1'b0;
        end else begin
            rx_ready_r <= rd_s & io_s & (io_reg_s == 3'd0) & rx_valid;
            if (rd_s) begin
                mem_din_r <= rd_data_s;
            end
            if (rdy_in) begin
                counter_r <= counter_r + 32'd1;
            end
            if (rd_s && io_s && (io_reg_s == 3'd4)) begin
                snap_r <= counter_r;
            end
            if (finish_set_s) begin
                finish_r <= 1'b1;
            end
            if (ovf_s) begin
                ovf_r <= 1'b1;
            end
        end
    end

    // TX FIFO storage and pointers; flags are registered from the next count
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < TXF_DEPTH; i++) begin
                fifo_r[i] <= 8'h00;
            end
            wr_ptr_r   <= {TXF_DEPTH_LOG{1'b0}};
            rd_ptr_r   <= {TXF_DEPTH_LOG{1'b0}};
            count_r    <= {CW{1'b0}};
            tx_valid_r <= 1'b0;
            buf_full_r <= 1'b0;
        end else begin
            if (accept_s) begin
                fifo_r[wr_ptr_r] <= push_data_s;
                wr_ptr_r         <= wr_ptr_r + PTR_ONE_C;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE_C;
            end
            count_r    <= count_nxt_s;
            tx_valid_r <= (count_nxt_s != {CW{1'b0}});
            buf_full_r <= (count_nxt_s >= FULL_LVL_C);
        end
    end

    assign mem_din        = mem_din_r;
    assign rx_ready       = rx_ready_r;
    assign program_finish = finish_r;
    assign tx_overflow    = ovf_r;
    assign tx_valid       = tx_valid_r;
    assign io_buffer_full = buf_full_r;
    assign tx_data        = fifo_r[rd_ptr_r];

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed bench for mem_io_responder: RAM, TX FIFO, RX pop, counter and reset.
module tb_mem_io_responder;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic [31:0] mem_a;
    logic [7:0]  mem_dout;
    logic        mem_wr;
    logic [7:0]  mem_din;
    logic        io_buffer_full;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        program_finish;
    logic        tx_overflow;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] tx_q [$];

    mem_io_responder dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .rdy_in        (rdy_in),
        .mem_a         (mem_a),
        .mem_dout      (mem_dout),
        .mem_wr        (mem_wr),
        .mem_din       (mem_din),
        .io_buffer_full(io_buffer_full),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_ready      (rx_ready),
        .program_finish(program_finish),
        .tx_overflow   (tx_overflow)
    );

    always #5 clk_in = ~clk_in;

    // Record every byte the UART side accepts
    always @(negedge clk_in) begin
        if (rst_in && tx_valid && tx_ready) begin
            tx_q.push_back(tx_data);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle();
        mem_a  = 32'h0000_0000;
        mem_wr = 1'b0;
    endtask

    task automatic wr_byte(input logic [31:0] addr, input logic [7:0] data);
        mem_a    = addr;
        mem_dout = data;
        mem_wr   = 1'b1;
        cyc();
        idle();
    endtask

    task automatic rd_addr(input logic [31:0] addr);
        mem_a  = addr;
        mem_wr = 1'b0;
        cyc();
        idle();
    endtask

    initial begin
        rst_in   = 1'b0;
        rdy_in   = 1'b1;
        mem_a    = 32'h0;
        mem_dout = 8'h00;
        mem_wr   = 1'b0;
        tx_ready = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        repeat (3) cyc();
        check_eq("rst_mem_din", {24'h0, mem_din}, 32'h0);
        check_eq("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
        check_eq("rst_buf_full", {31'h0, io_buffer_full}, 32'h0);
        check_eq("rst_rx_ready", {31'h0, rx_ready}, 32'h0);
        check_eq("rst_finish", {31'h0, program_finish}, 32'h0);
        check_eq("rst_overflow", {31'h0, tx_overflow}, 32'h0);
        rst_in = 1'b1;
        cyc();

        // RAM round trips, including top and bottom of the array
        wr_byte(32'h0001_0, 8'hA5);
        rd_addr(32'h0000_0010);
        check_eq("ram_10", {24'h0, mem_din}, 32'hA5);
        wr_byte(32'h0001_FFFF, 8'h5A);
        wr_byte(32'h0000_0000, 8'h33);
        check_eq("din_hold_on_wr", {24'h0, mem_din}, 32'hA5);
        rd_addr(32'h0001_FFFF);
        check_eq("ram_1ffff", {24'h0, mem_din}, 32'h5A);
        rd_addr(32'h0000_0000);
        check_eq("ram_0", {24'h0, mem_din}, 32'h33);
        rdy_in = 1'b0;
        wr_byte(32'h0000_0010, 8'hFF);
        rdy_in = 1'b1;
        rd_addr(32'h0000_0010);
        check_eq("ram_no_wr_rdy0", {24'h0, mem_din}, 32'hA5);

        // 'H','i',0x00 with the UART ready
        tx_ready = 1'b1;
        tx_q.delete();
        wr_byte(32'h0003_0000, 8'h48);
        wr_byte(32'h0003_0000, 8'h69);
        wr_byte(32'h0003_0000, 8'h00);
        repeat (4) cyc();
        check_eq("hi_count", tx_q.size(), 32'd2);
        check_eq("hi_0", {24'h0, tx_q[0]}, 32'h48);
        check_eq("hi_1", {24'h0, tx_q[1]}, 32'h69);
        check_eq("hi_empty", {31'h0, tx_valid}, 32'h0);

        // Fill with the UART stalled, overflow on the ninth, then drain
        tx_ready = 1'b0;
        tx_q.delete();
        for (int i = 1; i <= 9; i++) begin
            wr_byte(32'h0003_0000, 8'(i));
            if (i == 5) check_eq("full_after5", {31'h0, io_buffer_full}, 32'h0);
            if (i == 6) check_eq("full_after6", {31'h0, io_buffer_full}, 32'h1);
            if (i == 8) check_eq("ovf_after8", {31'h0, tx_overflow}, 32'h0);
        end
        check_eq("ovf_after9", {31'h0, tx_overflow}, 32'h1);
        tx_ready = 1'b1;
        repeat (12) cyc();
        check_eq("drain_count", tx_q.size(), 32'd8);
        for (int i = 0; i < 8; i++) begin
            check_eq($sformatf("drain_%0d", i), {24'h0, tx_q[i]}, i + 1);
        end
        check_eq("drain_valid", {31'h0, tx_valid}, 32'h0);
        check_eq("drain_full", {31'h0, io_buffer_full}, 32'h0);
        check_eq("ovf_sticky", {31'h0, tx_overflow}, 32'h1);

        // RX pop with and without data available
        rx_valid = 1'b1;
        rx_data  = 8'h3C;
        rd_addr(32'h0003_0000);
        rx_valid = 1'b0;
        check_eq("rx_data", {24'h0, mem_din}, 32'h3C);
        check_eq("rx_pulse", {31'h0, rx_ready}, 32'h1);
        cyc();
        check_eq("rx_pulse_end", {31'h0, rx_ready}, 32'h0);
        check_eq("ram0_again", {24'h0, mem_din}, 32'h33);
        rd_addr(32'h0003_0000);
        check_eq("rx_empty_data", {24'h0, mem_din}, 32'h00);
        check_eq("rx_empty_pulse", {31'h0, rx_ready}, 32'h0);
        rd_addr(32'h0001_0);
        rd_addr(32'h0003_0002);
        check_eq("io_other", {24'h0, mem_din}, 32'h00);

        // Program stop, then asynchronous reset mid-drain
        tx_q.delete();
        wr_byte(32'h0003_0004, 8'hFF);
        check_eq("finish_set", {31'h0, program_finish}, 32'h1);
        repeat (3) cyc();
        check_eq("term_count", tx_q.size(), 32'd1);
        check_eq("term_byte", {24'h0, tx_q[0]}, 32'h00);
        check_eq("finish_sticky", {31'h0, program_finish}, 32'h1);
        tx_ready = 1'b0;
        wr_byte(32'h0003_0000, 8'h11);
        wr_byte(32'h0003_0000, 8'h22);
        wr_byte(32'h0003_0000, 8'h33);
        rd_addr(32'h0000_0010);
        check_eq("pre_rst_din", {24'h0, mem_din}, 32'hA5);
        tx_ready = 1'b1;
        cyc();
        check_eq("pre_rst_valid", {31'h0, tx_valid}, 32'h1);
        #3;
        rst_in = 1'b0;
        #1;
        check_eq("arst_mem_din", {24'h0, mem_din}, 32'h0);
        check_eq("arst_tx_valid", {31'h0, tx_valid}, 32'h0);
        check_eq("arst_finish", {31'h0, program_finish}, 32'h0);
        check_eq("arst_overflow", {31'h0, tx_overflow}, 32'h0);
        check_eq("arst_buf_full", {31'h0, io_buffer_full}, 32'h0);
        check_eq("arst_rx_ready", {31'h0, rx_ready}, 32'h0);
        cyc();
        tx_ready = 1'b0;
        rst_in   = 1'b1;

        // Counter snapshot coherence and hold while rdy_in is low
        repeat (32'h12345) cyc();
        rd_addr(32'h0003_0004);
        check_eq("cnt_b0", {24'h0, mem_din}, 32'h45);
        rd_addr(32'h0003_0005);
        check_eq("cnt_b1", {24'h0, mem_din}, 32'h23);
        rd_addr(32'h0003_0006);
        check_eq("cnt_b2", {24'h0, mem_din}, 32'h01);
        rd_addr(32'h0003_0007);
        check_eq("cnt_b3", {24'h0, mem_din}, 32'h00);
        rdy_in = 1'b0;
        mem_a  = 32'h0003_0004;
        repeat (10) cyc();
        check_eq("rdy0_din_hold", {24'h0, mem_din}, 32'h00);
        rdy_in = 1'b1;
        rd_addr(32'h0003_0004);
        check_eq("cnt_held", {24'h0, mem_din}, 32'h49);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
